// File: rtl/pong_pkg.sv
// Shared screen geometry, colours and game-state encoding for the pong frame engine.
package pong_pkg;

    localparam int unsigned ACTIVE_COLS = 640;
    localparam int unsigned ACTIVE_ROWS = 480;

    localparam logic [8:0] COLOUR_BLACK = 9'b000_000_000;
    localparam logic [8:0] COLOUR_WHITE = 9'b111_111_111;
    localparam logic [8:0] COLOUR_GREY  = 9'b011_011_011;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPlay   = 2'd1,
        StScored = 2'd2,
        StOver   = 2'd3
    } game_state_e;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: 2-flop button synchronisers plus per-frame movement clamped to the screen.
module pong_paddle import pong_pkg::*; #(
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_SPEED = 4,
    parameter int unsigned RESET_Y      = 208
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       up_i,
    input  logic       dn_i,
    output logic       up_sync_o,
    output logic       dn_sync_o,
    output logic [9:0] y_o
);

    localparam logic [10:0] YMax = 11'(ACTIVE_ROWS - PADDLE_H);
    localparam logic [10:0] Step = 11'(PADDLE_SPEED);

    logic [1:0]  up_sync_q, dn_sync_q;
    logic [9:0]  y_d, y_q;
    logic [10:0] y_ext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_sync_q <= 2'b00;
            dn_sync_q <= 2'b00;
            y_q       <= 10'(RESET_Y);
        end else begin
            up_sync_q <= {up_sync_q[0], up_i};
            dn_sync_q <= {dn_sync_q[0], dn_i};
            y_q       <= y_d;
        end
    end

    assign up_sync_o = up_sync_q[1];
    assign dn_sync_o = dn_sync_q[1];
    assign y_ext     = {1'b0, y_q};

    // Both or neither pressed holds the paddle.
    always_comb begin
        y_d = y_q;
        if (tick_i && up_sync_o && !dn_sync_o) begin
            y_d = (y_ext < Step) ? 10'd0 : 10'(y_ext - Step);
        end else if (tick_i && dn_sync_o && !up_sync_o) begin
            y_d = (y_ext + Step > YMax) ? 10'(YMax) : 10'(y_ext + Step);
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_frame_engine.sv
// Pong game state and pixel generator behind a 640x480 VGA timing source.
// Define PONG_CENTER_LINE_EN to draw a dashed grey net down the middle.
module pong_frame_engine import pong_pkg::*; #(
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_SPEED = 4,
    parameter int unsigned P1_X         = 16,
    parameter int unsigned P2_X         = 616,
    parameter int unsigned HOLD_FRAMES  = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic [9:0] i_x_pos,
    input  logic [9:0] i_y_pos,
    input  logic       i_P1_up,
    input  logic       i_P1_dn,
    input  logic       i_P2_up,
    input  logic       i_P2_dn,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [2:0] o_Red,
    output logic [2:0] o_Grn,
    output logic [2:0] o_Blu,
    output logic [3:0] o_score_p1,
    output logic [3:0] o_score_p2
);

    localparam logic [10:0] Bs     = 11'(BALL_SIZE);
    localparam logic [10:0] Spd    = 11'(BALL_SPEED);
    localparam logic [10:0] Pw     = 11'(PADDLE_W);
    localparam logic [10:0] Ph     = 11'(PADDLE_H);
    localparam logic [10:0] P1x    = 11'(P1_X);
    localparam logic [10:0] P2x    = 11'(P2_X);
    localparam logic [10:0] P1Edge = P1x + Pw;
    localparam logic [10:0] Cols   = 11'(ACTIVE_COLS);
    localparam logic [10:0] Rows   = 11'(ACTIVE_ROWS);
    localparam logic [9:0]  BallX0 = 10'((ACTIVE_COLS - BALL_SIZE) / 2);
    localparam logic [9:0]  BallY0 = 10'((ACTIVE_ROWS - BALL_SIZE) / 2);
    localparam logic [7:0]  HoldLast = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0]  WinScore = 4'(WIN_SCORE);

    logic        tick, any_btn;
    logic        p1_up_s, p1_dn_s, p2_up_s, p2_dn_s;
    logic [9:0]  p1_y, p2_y;
    game_state_e state_d, state_q;
    logic [9:0]  bx_d, bx_q, by_d, by_q, by_mv;
    logic        dx_d, dx_q, dy_d, dy_q, dy_mv, serve_dx_d, serve_dx_q;
    logic [7:0]  hold_d, hold_q;
    logic [3:0]  score1_d, score1_q, score2_d, score2_q;
    logic [8:0]  rgb_d, rgb_q;
    logic        hsync_q, vsync_q;
    logic [10:0] bx_e, by_e, x_e, y_e, p1y_e, p2y_e;
    logic        hit1, hit2, miss_l, miss_r, on_ball, on_p1, on_p2;

    pong_paddle #(
        .PADDLE_H    (PADDLE_H),
        .PADDLE_SPEED(PADDLE_SPEED),
        .RESET_Y     ((ACTIVE_ROWS - PADDLE_H) / 2)
    ) u_p1 (
        .clk_i    (i_CLK),
        .rst_ni   (i_RST_N),
        .tick_i   (tick),
        .up_i     (i_P1_up),
        .dn_i     (i_P1_dn),
        .up_sync_o(p1_up_s),
        .dn_sync_o(p1_dn_s),
        .y_o      (p1_y)
    );

    pong_paddle #(
        .PADDLE_H    (PADDLE_H),
        .PADDLE_SPEED(PADDLE_SPEED),
        .RESET_Y     ((ACTIVE_ROWS - PADDLE_H) / 2)
    ) u_p2 (
        .clk_i    (i_CLK),
        .rst_ni   (i_RST_N),
        .tick_i   (tick),
        .up_i     (i_P2_up),
        .dn_i     (i_P2_dn),
        .up_sync_o(p2_up_s),
        .dn_sync_o(p2_dn_s),
        .y_o      (p2_y)
    );

    assign tick    = (i_x_pos == 10'd0) && (i_y_pos == 10'd480);
    assign any_btn = p1_up_s | p1_dn_s | p2_up_s | p2_dn_s;
    assign bx_e    = {1'b0, bx_q};
    assign by_e    = {1'b0, by_q};
    assign x_e     = {1'b0, i_x_pos};
    assign y_e     = {1'b0, i_y_pos};
    assign p1y_e   = {1'b0, p1_y};
    assign p2y_e   = {1'b0, p2_y};

    // Candidate ball motion for this frame; only committed in PLAY on a tick.
    always_comb begin
        by_mv = by_q;
        dy_mv = dy_q;
        if (dy_q) begin
            if (by_e + Bs + Spd >= Rows) begin
                by_mv = 10'(Rows - Bs);
                dy_mv = 1'b0;
            end else begin
                by_mv = 10'(by_e + Spd);
            end
        end else if (by_e < Spd) begin
            by_mv = 10'd0;
            dy_mv = 1'b1;
        end else begin
            by_mv = 10'(by_e - Spd);
        end
        hit1   = !dx_q && (bx_e >= P1Edge) && (bx_e < P1Edge + Spd)
                 && (by_e + Bs > p1y_e) && (by_e < p1y_e + Ph);
        hit2   = dx_q && (bx_e + Bs > P2x - Spd) && (bx_e + Bs <= P2x)
                 && (by_e + Bs > p2y_e) && (by_e < p2y_e + Ph);
        miss_l = !dx_q && !hit1 && (bx_e < Spd);
        miss_r = dx_q && !hit2 && (bx_e + Bs + Spd > Cols);
    end

    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        serve_dx_d = serve_dx_q;
        hold_d     = hold_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (any_btn) begin
                        state_d = StPlay;
                        dx_d    = serve_dx_q;
                        dy_d    = 1'b1;
                    end
                end
                StPlay: begin
                    by_d = by_mv;
                    dy_d = dy_mv;
                    if (hit1) begin
                        bx_d = 10'(P1Edge);
                        dx_d = 1'b1;
                    end else if (hit2) begin
                        bx_d = 10'(P2x - Bs);
                        dx_d = 1'b0;
                    end else if (miss_l) begin
                        score2_d   = score2_q + 4'd1;
                        serve_dx_d = 1'b0;
                        hold_d     = 8'd0;
                        state_d    = StScored;
                    end else if (miss_r) begin
                        score1_d   = score1_q + 4'd1;
                        serve_dx_d = 1'b1;
                        hold_d     = 8'd0;
                        state_d    = StScored;
                    end else begin
                        bx_d = dx_q ? 10'(bx_e + Spd) : 10'(bx_e - Spd);
                    end
                end
                StScored: begin
                    if (hold_q == HoldLast) begin
                        state_d = (score1_q == WinScore || score2_q == WinScore) ? StOver : StIdle;
                        bx_d    = BallX0;
                        by_d    = BallY0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: begin
                    if (any_btn) begin
                        score1_d = 4'd0;
                        score2_d = 4'd0;
                        state_d  = StIdle;
                    end
                end
            endcase
        end
    end

    always_comb begin
        on_ball = (state_q != StOver) && (x_e >= bx_e) && (x_e < bx_e + Bs)
                  && (y_e >= by_e) && (y_e < by_e + Bs);
        on_p1   = (x_e >= P1x) && (x_e < P1x + Pw) && (y_e >= p1y_e) && (y_e < p1y_e + Ph);
        on_p2   = (x_e >= P2x) && (x_e < P2x + Pw) && (y_e >= p2y_e) && (y_e < p2y_e + Ph);
        rgb_d   = COLOUR_BLACK;
        if ((x_e < Cols) && (y_e < Rows)) begin
            if (on_ball || on_p1 || on_p2) begin
                rgb_d = COLOUR_WHITE;
            end
`ifdef PONG_CENTER_LINE_EN
            else if ((x_e >= 11'd318) && (x_e <= 11'd321) && !i_y_pos[4]) begin
                rgb_d = COLOUR_GREY;
            end
`endif
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= StIdle;
            bx_q       <= BallX0;
            by_q       <= BallY0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            serve_dx_q <= 1'b1;
            hold_q     <= 8'd0;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            rgb_q      <= COLOUR_BLACK;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            serve_dx_q <= serve_dx_d;
            hold_q     <= hold_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            rgb_q      <= rgb_d;
            hsync_q    <= i_HSync;
            vsync_q    <= i_VSync;
        end
    end

    assign o_HSync    = hsync_q;
    assign o_VSync    = vsync_q;
    assign o_Red      = rgb_q[8:6];
    assign o_Grn      = rgb_q[5:3];
    assign o_Blu      = rgb_q[2:0];
    assign o_score_p1 = score1_q;
    assign o_score_p2 = score2_q;

endmodule

// File: tb/tb_pong_frame_engine.sv
// Directed bench for pong_frame_engine: reset, pixel latency, paddles, walls, hits, scoring.
module tb_pong_frame_engine;

    logic       clk, rst_n, hs, vs;
    logic [9:0] x, y;
    logic       p1u, p1d, p2u, p2d;
    logic       o_hs, o_vs;
    logic [2:0] r, g, b;
    logic [3:0] s1, s2;

    int n_cmp = 0;
    int n_bad = 0;

    pong_frame_engine dut (
        .i_CLK     (clk),
        .i_RST_N   (rst_n),
        .i_HSync   (hs),
        .i_VSync   (vs),
        .i_x_pos   (x),
        .i_y_pos   (y),
        .i_P1_up   (p1u),
        .i_P1_dn   (p1d),
        .i_P2_up   (p2u),
        .i_P2_dn   (p2d),
        .o_HSync   (o_hs),
        .o_VSync   (o_vs),
        .o_Red     (r),
        .o_Grn     (g),
        .o_Blu     (b),
        .o_score_p1(s1),
        .o_score_p2(s2)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rgb();
        return int'({r, g, b});
    endfunction

    // Each frame: three idle cycles (lets buttons through the synchroniser), then the tick.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            x = 10'd0;
            y = 10'd480;
            @(posedge clk);
            #1;
            x = 10'd700;
            y = 10'd700;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #5 rst_n = 1'b0;
        #10 rst_n = 1'b1;
    endtask

    task automatic show_pixel(input int px, input int py);
        x = 10'(px);
        y = 10'(py);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1;
        x = 10'd700; y = 10'd700;
        p1u = 1'b0; p1d = 1'b0; p2u = 1'b0; p2d = 1'b0;
        #50 rst_n = 1'b1;

        // Disturb state, then reset asynchronously in the middle of a line.
        p1d = 1'b1;
        tick_n(2);
        p1d = 1'b0;
        x = 10'd100; y = 10'd100; hs = 1'b0; vs = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #4 check_eq("hsync_delayed_low", int'(o_hs), 0);
        check_eq("p1_moved_before_rst", int'(dut.p1_y), 216);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_hsync", int'(o_hs), 1);
        check_eq("rst_vsync", int'(o_vs), 1);
        check_eq("rst_rgb", rgb(), 0);
        check_eq("rst_score_p1", int'(s1), 0);
        check_eq("rst_score_p2", int'(s2), 0);
        check_eq("rst_state", int'(dut.state_q), 0);
        check_eq("rst_bx", int'(dut.bx_q), 316);
        check_eq("rst_by", int'(dut.by_q), 236);
        check_eq("rst_p1y", int'(dut.p1_y), 208);
        check_eq("rst_p2y", int'(dut.p2_y), 208);
        #9 rst_n = 1'b1;
        hs = 1'b1; vs = 1'b1; x = 10'd700; y = 10'd700;

        // Pixel path: one cycle of latency, syncs aligned.
        @(posedge clk);
        #1;
        x = 10'd320; y = 10'd240; hs = 1'b0;
        #1 check_eq("rgb_before_edge", rgb(), 0);
        @(posedge clk);
        #1;
        check_eq("ball_px", rgb(), 511);
        check_eq("hsync_aligned", int'(o_hs), 0);
        hs = 1'b1;
        show_pixel(700, 240);
        check_eq("offscreen_x", rgb(), 0);
        show_pixel(20, 210);
        check_eq("p1_px", rgb(), 511);
        show_pixel(20, 207);
        check_eq("above_p1", rgb(), 0);
        show_pixel(619, 271);
        check_eq("p2_bottom_px", rgb(), 511);
        show_pixel(319, 0);
`ifdef PONG_CENTER_LINE_EN
        check_eq("net_px", rgb(), 219);
`else
        check_eq("net_px", rgb(), 0);
`endif
        x = 10'd700; y = 10'd700;

        // Paddle stepping and clamping.
        do_reset();
        p1u = 1'b1; p2d = 1'b1;
        tick_n(51);
        check_eq("p1_after_51", int'(dut.p1_y), 4);
        check_eq("p2_after_51", int'(dut.p2_y), 412);
        tick_n(1);
        check_eq("p1_top_clamp", int'(dut.p1_y), 0);
        check_eq("p2_bot_clamp", int'(dut.p2_y), 416);
        tick_n(8);
        check_eq("p1_stays_0", int'(dut.p1_y), 0);
        check_eq("p2_stays_416", int'(dut.p2_y), 416);
        p1u = 1'b0; p2d = 1'b0;
        do_reset();
        p1u = 1'b1; p1d = 1'b1;
        tick_n(5);
        check_eq("both_hold", int'(dut.p1_y), 208);
        check_eq("btn_starts_play", int'(dut.state_q), 1);
        p1u = 1'b0; p1d = 1'b0;

        // Serve right, bounce off the bottom wall, miss past a P2 paddle parked at the top.
        do_reset();
        p2u = 1'b1;
        tick_n(118);
        check_eq("by_before_wall", int'(dut.by_q), 470);
        check_eq("dy_before_wall", int'(dut.dy_q), 1);
        check_eq("bx_tick118", int'(dut.bx_q), 550);
        tick_n(1);
        check_eq("by_wall", int'(dut.by_q), 472);
        check_eq("dy_wall", int'(dut.dy_q), 0);
        tick_n(40);
        check_eq("bx_before_miss", int'(dut.bx_q), 632);
        check_eq("s1_before_miss", int'(s1), 0);
        tick_n(1);
        check_eq("s1_after_miss", int'(s1), 1);
        check_eq("state_scored", int'(dut.state_q), 2);
        tick_n(30);
        check_eq("hold_30", int'(dut.hold_q), 30);
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        check_eq("midhold_rst_state", int'(dut.state_q), 0);
        check_eq("midhold_rst_hold", int'(dut.hold_q), 0);
        check_eq("midhold_rst_s1", int'(s1), 0);
        #9 rst_n = 1'b1;

        // P1 wins 9-0; check the hold length each point, then OVER behaviour.
        for (int p = 1; p <= 9; p++) begin
            tick_n(160);
            check_eq($sformatf("s1_point%0d", p), int'(s1), p);
            tick_n(59);
            check_eq($sformatf("hold59_p%0d", p), int'(dut.state_q), 2);
            tick_n(1);
            check_eq($sformatf("after_hold_p%0d", p), int'(dut.state_q), (p == 9) ? 3 : 0);
        end
        check_eq("s2_zero_at_over", int'(s2), 0);
        show_pixel(320, 240);
        check_eq("over_ball_hidden", rgb(), 0);
        show_pixel(620, 10);
        check_eq("over_p2_drawn", rgb(), 511);
        x = 10'd700; y = 10'd700;
        tick_n(1);
        check_eq("over_to_idle", int'(dut.state_q), 0);
        check_eq("over_clears_s1", int'(s1), 0);
        show_pixel(320, 240);
        check_eq("idle_ball_drawn", rgb(), 511);
        x = 10'd700; y = 10'd700;
        p2u = 1'b0;

        // Right-paddle hit, then left-paddle hit with P1 overlapping the ball.
        do_reset();
        p2d = 1'b1; p1u = 1'b1;
        tick_n(9);
        p1u = 1'b0;
        check_eq("p1_at_172", int'(dut.p1_y), 172);
        tick_n(139);
        check_eq("p2_hit_bx", int'(dut.bx_q), 608);
        check_eq("p2_hit_dx", int'(dut.dx_q), 0);
        check_eq("p2_hit_by", int'(dut.by_q), 414);
        tick_n(291);
        check_eq("bx_26", int'(dut.bx_q), 26);
        check_eq("by_166", int'(dut.by_q), 166);
        tick_n(1);
        check_eq("bx_24_pre_hit", int'(dut.bx_q), 24);
        check_eq("dx_pre_hit", int'(dut.dx_q), 0);
        tick_n(1);
        check_eq("p1_hit_bx", int'(dut.bx_q), 24);
        check_eq("p1_hit_dx", int'(dut.dx_q), 1);

        // Same trajectory with P1 left at 208: ball misses on the left.
        do_reset();
        tick_n(452);
        check_eq("bx_at_left_wall", int'(dut.bx_q), 0);
        check_eq("s2_before_miss", int'(s2), 0);
        tick_n(1);
        check_eq("s2_after_miss", int'(s2), 1);
        check_eq("state_scored_p2", int'(dut.state_q), 2);
        tick_n(60);
        check_eq("idle_after_p2", int'(dut.state_q), 0);
        check_eq("idle_bx_centre", int'(dut.bx_q), 316);
        tick_n(1);
        check_eq("serve_left_state", int'(dut.state_q), 1);
        check_eq("serve_left_dx", int'(dut.dx_q), 0);
        check_eq("serve_left_dy", int'(dut.dy_q), 1);
        p2d = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
